// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: opcodes, queue geometry, FSM states
// and the CDB snoop helpers used both at enqueue and while entries wait.
package load_store_unit_pkg;

  localparam logic [3:0] LSU_OP_LD     = 4'b1000;
  localparam logic [3:0] LSU_OP_ST     = 4'b1001;
  localparam int         LSU_DEPTH     = 4;
  localparam int         LSU_PTR_W     = 2;
  localparam int         LSU_CDB_SLOTS = 4;
  localparam int         DMEM_WORDS    = 256;
  localparam int         DMEM_AW       = 8;

  typedef enum logic [1:0] {
    IDLE,
    LD_WAIT,
    RESP
  } lsu_state_e;

  typedef struct packed {
    logic [3:0]  rob_idx;
    logic [3:0]  opcode;
    logic        a_valid;
    logic [15:0] a_value;
    logic [3:0]  a_owner;
    logic        b_valid;
    logic [15:0] b_value;
    logic [3:0]  b_owner;
  } lsu_entry_t;

  typedef struct packed {
    logic        hit;
    logic [15:0] value;
  } cdb_hit_t;

  // Walk from the highest slot down so the lowest matching slot is the one kept.
  function automatic cdb_hit_t cdb_lookup(input logic [3:0]  owner,
                                          input logic [3:0]  vld,
                                          input logic [15:0] idx,
                                          input logic [63:0] vals);
    cdb_hit_t r;
    r = '0;
    for (int k = LSU_CDB_SLOTS - 1; k >= 0; k--) begin
      if (vld[k] && (idx[15-4*k -: 4] == owner)) begin
        r.hit   = 1'b1;
        r.value = vals[63-16*k -: 16];
      end
    end
    return r;
  endfunction

  function automatic lsu_entry_t snoop_entry(input lsu_entry_t  e,
                                             input logic [3:0]  vld,
                                             input logic [15:0] idx,
                                             input logic [63:0] vals);
    lsu_entry_t r;
    cdb_hit_t   ha;
    cdb_hit_t   hb;
    r  = e;
    ha = cdb_lookup(e.a_owner, vld, idx, vals);
    hb = cdb_lookup(e.b_owner, vld, idx, vals);
    if (!e.a_valid && ha.hit) begin
      r.a_valid = 1'b1;
      r.a_value = ha.value;
    end
    if (!e.b_valid && hb.hit) begin
      r.b_valid = 1'b1;
      r.b_value = hb.value;
    end
    return r;
  endfunction

endpackage

// File: rtl/lsu_data_ram.sv
// 256x16 data memory: synchronous write, registered read with one cycle of latency.
// Contents are deliberately left unreset.
module lsu_data_ram
  import load_store_unit_pkg::*;
(
  input  logic               clk,
  input  logic               we_i,
  input  logic [DMEM_AW-1:0] waddr_i,
  input  logic [15:0]        wdata_i,
  input  logic               re_i,
  input  logic [DMEM_AW-1:0] raddr_i,
  output logic [15:0]        rdata_o
);

  logic [15:0] mem_q [DMEM_WORDS];
  logic [15:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/load_store_unit.sv
// In-order load/store unit: 4-entry circular queue snooping the CDB, head-only
// execution, results broadcast on CDB slot 2.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [3:0]  in_rob_idx,
  input  logic [3:0]  in_opcode,
  input  logic        in_a_valid,
  input  logic [15:0] in_a_value,
  input  logic [3:0]  in_a_owner,
  input  logic        in_b_valid,
  input  logic [15:0] in_b_value,
  input  logic [3:0]  in_b_owner,
  output logic        lsu_full,
  input  logic [3:0]  rob_head,
  input  logic [3:0]  cdb_valid_in,
  input  logic [15:0] cdb_indices_in,
  input  logic [63:0] cdb_values_in,
  output logic        cdb_valid,
  output logic [3:0]  cdb_index,
  output logic [15:0] cdb_value
);

  lsu_entry_t           ent_q [LSU_DEPTH];
  lsu_entry_t           ent_d [LSU_DEPTH];
  lsu_entry_t           new_ent;
  logic [LSU_PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [2:0]           count_q, count_d;
  lsu_state_e           state_q, state_d;
  logic [3:0]           resp_idx_q, resp_idx_d;
  logic [15:0]          resp_val_q, resp_val_d;
  logic                 enq, deq, issue_ld, issue_st;
  logic [DMEM_AW-1:0]   ram_addr;
  logic [15:0]          ram_rdata;

  // Full is taken from the registered count only, so a same-cycle dequeue never frees a slot.
  assign lsu_full = (count_q == 3'(LSU_DEPTH));
  assign enq      = in_valid && !lsu_full;
  assign deq      = issue_ld || issue_st;
  assign ram_addr = ent_q[head_q].a_value[DMEM_AW-1:0];

  always_comb begin
    new_ent.rob_idx = in_rob_idx;
    new_ent.opcode  = in_opcode;
    new_ent.a_valid = in_a_valid;
    new_ent.a_value = in_a_value;
    new_ent.a_owner = in_a_owner;
    new_ent.b_valid = in_b_valid;
    new_ent.b_value = in_b_value;
    new_ent.b_owner = in_b_owner;
  end

  always_comb begin
    for (int i = 0; i < LSU_DEPTH; i++) begin
      ent_d[i] = snoop_entry(ent_q[i], cdb_valid_in, cdb_indices_in, cdb_values_in);
    end
    if (enq) begin
      ent_d[tail_q] = snoop_entry(new_ent, cdb_valid_in, cdb_indices_in, cdb_values_in);
    end
  end

  always_comb begin
    head_d  = head_q + LSU_PTR_W'(deq);
    tail_d  = tail_q + LSU_PTR_W'(enq);
    count_d = count_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // Unknown opcodes fall through to the load path.
  always_comb begin
    state_d    = state_q;
    issue_ld   = 1'b0;
    issue_st   = 1'b0;
    resp_idx_d = resp_idx_q;
    resp_val_d = resp_val_q;
    case (state_q)
      IDLE: begin
        if ((count_q != 3'd0) && ent_q[head_q].a_valid) begin
          if (ent_q[head_q].opcode == LSU_OP_ST) begin
            if (ent_q[head_q].b_valid && (ent_q[head_q].rob_idx == rob_head)) begin
              issue_st   = 1'b1;
              resp_idx_d = ent_q[head_q].rob_idx;
              resp_val_d = 16'h0000;
              state_d    = RESP;
            end
          end else begin
            issue_ld   = 1'b1;
            resp_idx_d = ent_q[head_q].rob_idx;
            state_d    = LD_WAIT;
          end
        end
      end
      LD_WAIT: begin
        resp_val_d = ram_rdata;
        state_d    = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload registers carry no reset; occupancy and FSM state qualify them.
  always_ff @(posedge clk) begin
    ent_q      <= ent_d;
    resp_idx_q <= resp_idx_d;
    resp_val_q <= resp_val_d;
  end

  assign cdb_valid = (state_q == RESP);
  assign cdb_index = cdb_valid ? resp_idx_q : 4'h0;
  assign cdb_value = cdb_valid ? resp_val_q : 16'h0000;

  lsu_data_ram u_ram (
    .clk     (clk),
    .we_i    (issue_st),
    .waddr_i (ram_addr),
    .wdata_i (ent_q[head_q].b_value),
    .re_i    (issue_ld),
    .raddr_i (ram_addr),
    .rdata_o (ram_rdata)
  );

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge; rst  in  1  asynchronous active-high reset.
REQ-002 SHALL have dispatch ports from the instruction buffer: in_valid in 1; in_rob_idx in 4; in_opcode in 4; in_a_valid in 1; in_a_value in 16 (address); in_a_owner in 4; in_b_valid in 1; in_b_value in 16 (store data); in_b_owner in 4.
REQ-003 SHALL drive lsu_full  out  1: queue cannot accept dispatch this cycle.
REQ-004 SHALL have rob_head  in  4: ROB index of the oldest uncommitted instruction.
REQ-005 SHALL have CDB snoop inputs: cdb_valid_in in 4; cdb_indices_in in 16; cdb_values_in in 64; slot k uses valid[k], indices[15-4k:12-4k], values[63-16k:48-16k].
REQ-006 SHALL drive CDB slot 2 outputs: cdb_valid out 1; cdb_index out 4; cdb_value out 16.

Function
REQ-007 SHALL hold a 4-entry in-order circular queue; each entry: rob_idx, opcode, a/b valid, value, owner.
REQ-008 lsu_full SHALL equal (count == 4), derived from registered count only; dispatch while full SHALL be dropped, even when the head dequeues in the same cycle.
REQ-009 On enqueue, an operand with valid=0 whose owner matches a same-cycle CDB slot SHALL be captured as valid with that slot's value.
REQ-010 Every cycle, each queued operand with valid=0 SHALL capture from any CDB slot whose index equals its owner; if several match, lowest slot wins.
REQ-011 Opcodes SHALL be LSU_OP_LD = 4'b1000 and LSU_OP_ST = 4'b1001; any other opcode SHALL be treated as a load.
REQ-012 Only the head entry SHALL execute; loads and stores SHALL execute strictly in program order.
REQ-013 The FSM SHALL have states IDLE, LD_WAIT, RESP.
REQ-014 IDLE to LD_WAIT: head is a load with a_valid=1; in the same cycle, issue a RAM read at address a_value[7:0] and dequeue the head.
REQ-015 LD_WAIT to RESP: unconditional after 1 cycle; latch RAM read data and rob_idx.
REQ-016 IDLE to RESP for a store: head is a store with a_valid=1, b_valid=1, and rob_idx == rob_head; in the same cycle, write b_value to RAM[a_value[7:0]] and dequeue the head.
REQ-017 RESP SHALL assert cdb_valid for exactly one cycle with cdb_index = rob_idx and cdb_value = load data (loads) or 16'h0000 (stores), then return to IDLE.
REQ-018 Load latency SHALL be: issue at cycle N, cdb_valid at N+2. Store latency SHALL be: write at N, cdb_valid at N+1. Throughput: at most one operation per 2 cycles (load: 3).
REQ-019 Head/tail pointers SHALL wrap modulo 4. Simultaneous enqueue and dequeue SHALL leave count unchanged.
REQ-020 cdb_index and cdb_value SHALL be 0 whenever cdb_valid=0.

Reset
REQ-021 rst SHALL, asynchronously: clear count and pointers, force the FSM to IDLE, and drive cdb_valid=0, cdb_index=0, cdb_value=0, lsu_full=0.
REQ-022 rst asserted mid-operation SHALL abort any in-flight load or store with no CDB broadcast; a RAM write already clocked SHALL stand.
REQ-023 RAM contents SHALL NOT be reset.

Structure
REQ-024 A shared package SHALL hold LSU_OP_LD, LSU_OP_ST, LSU_DEPTH=4, DMEM_WORDS=256, and the FSM state enum.
REQ-025 Sub-module lsu_data_ram SHALL provide 256x16 storage, synchronous write, and 1-cycle registered read.

Verification
REQ-026 Store then load: dispatch ST (a=0x0010, b=0xBEEF, rob 3) with rob_head=3, then LD (a=0x0010, rob 4) -> cdb (3, 0x0000), then cdb (4, 0xBEEF) 2 cycles after the load issues.
REQ-027 Pending operand: dispatch LD with a_valid=0, owner=5; CDB slot 0 later broadcasts (5, 0x0020) -> the load issues the next cycle and reads RAM[0x20].
REQ-028 Commit gating: a ready ST (rob 6) with rob_head=5 stays queued; rob_head=6 -> write occurs and cdb (6, 0) appears the next cycle.
REQ-029 Full: dispatch 4 entries with a_valid=0 -> lsu_full=1; a fifth dispatch is dropped; after one dequeue lsu_full=0 and the queue order is preserved across pointer wrap.
REQ-030 Reset mid-load: assert rst during LD_WAIT -> no cdb_valid pulse, all outputs 0, queue empty.
